// File: rtl/md_sched_pkg.sv
// rtl/md_sched_pkg.sv - shared multiply/divide op codes, latency defaults and decode helpers
//
// Package md_defs
//   md_op_e             : 3-bit operation code presented to md_sched with start
//   MD_MULT_CYCLES_DEF  : default busy cycles for mult/multu
//   MD_DIV_CYCLES_DEF   : default busy cycles for div/divu
//   md_is_long_op()     : op occupies the unit for several cycles
//   md_is_mt_op()       : op writes HI or LO directly in one cycle
//   md_funct_is_md()    : R-type funct field belongs to the MD class (hazard unit InstrType)
package md_defs;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // MIPS SPECIAL funct codes for the HI/LO instruction group
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  function automatic logic md_is_long_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_mt_op(input md_op_e op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

  function automatic logic md_funct_is_md(input logic [5:0] funct);
    return (funct == FUNCT_MFHI) || (funct == FUNCT_MTHI) ||
           (funct == FUNCT_MFLO) || (funct == FUNCT_MTLO) ||
           (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
           (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/md_sched.sv
// rtl/md_sched.sv - multi-cycle multiply/divide scheduler owning HI/LO
//
// Ports
//   clk       : system clock, rising edge
//   reset     : synchronous active-low reset; aborts an op in flight
//   start     : E-stage MD instruction valid this cycle
//   md_op     : md_op_e code, sampled when start=1
//   A, B      : forwarded rs / rt operands
//   md_use_D  : D-stage instruction is an MD-class instruction
//   mf_sel    : mfhi/mflo read select (0=LO, 1=HI)
//   md_out    : selected HI/LO value
//   hi, lo    : committed HI/LO registers
//   busy      : multi-cycle op in flight
//   md_stall  : stall request for PC/IR_D enable and IR_E clear
module md_sched
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use_D,
  input  logic        mf_sel,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_stall
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      temp_hi_q, temp_hi_d;
  logic [31:0]      temp_lo_q, temp_lo_d;
  logic             suppress_q, suppress_d;

  md_op_e op;

  // Arithmetic on 64-bit values so that the 0x80000000 / -1 overflow
  // case lands on quotient 0x80000000, remainder 0 without special logic.
  logic        [63:0] prod_s, prod_u;
  logic signed [63:0] a_s64, b_s64;
  logic signed [63:0] quot_s, rem_s;
  logic        [63:0] a_u64, b_u64;
  logic        [63:0] quot_u, rem_u;
  logic        [31:0] div_b;
  logic               unused_upper;

  always_comb begin
    // A zero divisor is replaced by 1 so the dividers never see 0; the
    // result is discarded anyway because the commit is suppressed.
    div_b  = (B == 32'd0) ? 32'd1 : B;
    a_s64  = {{32{A[31]}}, A};
    b_s64  = {{32{B[31]}}, B};
    a_u64  = {32'd0, A};
    b_u64  = {32'd0, B};
    prod_s = a_s64 * b_s64;
    prod_u = a_u64 * b_u64;
    quot_s = a_s64 / $signed({{32{div_b[31]}}, div_b});
    rem_s  = a_s64 % $signed({{32{div_b[31]}}, div_b});
    quot_u = a_u64 / {32'd0, div_b};
    rem_u  = a_u64 % {32'd0, div_b};
  end

  assign unused_upper = ^{quot_s[63:32], rem_s[63:32], quot_u[63:32], rem_u[63:32]};

  always_comb begin
    op         = md_op_e'(md_op);
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    temp_hi_d  = temp_hi_q;
    temp_lo_d  = temp_lo_q;
    suppress_d = suppress_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MD_MULT: begin
              {temp_hi_d, temp_lo_d} = prod_s;
              suppress_d = 1'b0;
              cnt_d      = CNT_W'(MULT_CYCLES);
              state_d    = ST_RUN;
            end
            MD_MULTU: begin
              {temp_hi_d, temp_lo_d} = prod_u;
              suppress_d = 1'b0;
              cnt_d      = CNT_W'(MULT_CYCLES);
              state_d    = ST_RUN;
            end
            MD_DIV: begin
              temp_lo_d  = quot_s[31:0];
              temp_hi_d  = rem_s[31:0];
              suppress_d = (B == 32'd0);
              cnt_d      = CNT_W'(DIV_CYCLES);
              state_d    = ST_RUN;
            end
            MD_DIVU: begin
              temp_lo_d  = quot_u[31:0];
              temp_hi_d  = rem_u[31:0];
              suppress_d = (B == 32'd0);
              cnt_d      = CNT_W'(DIV_CYCLES);
              state_d    = ST_RUN;
            end
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        // start is ignored here; md_stall keeps a new MD op out of E.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (!suppress_q) begin
            hi_d = temp_hi_q;
            lo_d = temp_lo_q;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      temp_hi_q  <= '0;
      temp_lo_q  <= '0;
      suppress_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      temp_hi_q  <= temp_hi_d;
      temp_lo_q  <= temp_lo_d;
      suppress_q <= suppress_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_out   = mf_sel ? hi_q : lo_q;
  assign md_stall = md_use_D & (start | busy);

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - scoreboard bench for md_sched with a behavioural HI/LO model
module tb_md_sched;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        md_use_D = 1'b0;
  logic        mf_sel = 1'b0;
  logic [31:0] md_out, hi, lo;
  logic        busy, md_stall;

  md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .md_use_D(md_use_D), .mf_sel(mf_sel), .md_out(md_out), .hi(hi), .lo(lo),
    .busy(busy), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  bit          mon_en = 1'b0;
  bit          abort_flag = 1'b0;
  bit          busy_prev = 1'b0;
  int          busy_len = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every falling edge of busy is a commit (or an abort by reset).
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy === 1'b1) begin
        busy_len++;
      end else if (busy_prev) begin
        if (abort_flag) begin
          abort_flag = 1'b0;
        end else if (exp_q.size() == 0) begin
          chk("unexpected_commit", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("commit_hi", {32'd0, hi}, {32'd0, e.hi});
          chk("commit_lo", {32'd0, lo}, {32'd0, e.lo});
          chk("busy_len", 64'(busy_len), 64'(e.len));
        end
        busy_len = 0;
      end
      busy_prev = (busy === 1'b1);
    end
  end

  // Reference model: MIPS HI/LO semantics in plain 64-bit arithmetic.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned up;
    logic [63:0]     p;
    exp_t            e;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd1, 3'd2: begin
        if (op == 3'd1) p = sa * sb;
        else begin
          up = longint'({32'd0, a}) * longint'({32'd0, b});
          p  = up;
        end
        m_hi = p[63:32];
        m_lo = p[31:0];
        e.hi = m_hi; e.lo = m_lo; e.len = MULT_N;
        exp_q.push_back(e);
      end
      3'd3, 3'd4: begin
        if (b != 32'd0) begin
          if (op == 3'd3) begin
            sq = sa / sb;
            sr = sa % sb;
            m_lo = sq[31:0];
            m_hi = sr[31:0];
          end else begin
            m_lo = a / b;
            m_hi = a % b;
          end
        end
        e.hi = m_hi; e.lo = m_lo; e.len = DIV_N;
        exp_q.push_back(e);
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  // Drives one start cycle; returns one cycle after the start edge (posedge+1).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic use_d);
    @(posedge clk); #1;
    start = 1'b1; md_op = op; A = a; B = b; md_use_D = use_d;
    model_op(op, a, b);
    @(negedge clk);
    chk("stall_start", {63'd0, md_stall}, {63'd0, use_d});
    @(posedge clk); #1;
    start = 1'b0;
    if (op == 3'd0 || op >= 3'd5) begin
      chk("mt_busy", {63'd0, busy}, 64'd0);
      chk("mt_hi", {32'd0, hi}, {32'd0, m_hi});
      chk("mt_lo", {32'd0, lo}, {32'd0, m_lo});
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 40);
    chk("idle_bound", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_regs(input string name);
    chk({name, "_hi"}, {32'd0, hi}, {32'd0, m_hi});
    chk({name, "_lo"}, {32'd0, lo}, {32'd0, m_lo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;

    // Reset
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_stall", {63'd0, md_stall}, 64'd0);
    mon_en = 1'b1;

    // 1: MULT -3 * 5
    issue(3'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
    wait_idle();
    chk("t1_hi", {32'd0, hi}, 64'hFFFFFFFF);
    chk("t1_lo", {32'd0, lo}, 64'hFFFFFFF1);

    // 2: MULTU and DIV
    issue(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    wait_idle();
    chk("t2_hi", {32'd0, hi}, 64'h1);
    chk("t2_lo", {32'd0, lo}, 64'hFFFFFFFE);
    issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle();
    chk("t2d_lo", {32'd0, lo}, 64'hFFFFFFFD);
    chk("t2d_hi", {32'd0, hi}, 64'hFFFFFFFF);

    // 3: preload then divide by zero keeps HI/LO
    issue(3'd5, 32'h1234, 32'd0, 1'b0);
    issue(3'd6, 32'h5678, 32'd0, 1'b0);
    issue(3'd4, 32'd9, 32'd0, 1'b0);
    wait_idle();
    chk("t3_hi", {32'd0, hi}, 64'h1234);
    chk("t3_lo", {32'd0, lo}, 64'h5678);

    // 4: stall behaviour
    issue(3'd4, 32'd100, 32'd7, 1'b1);
    for (int i = 0; i < DIV_N; i++) begin
      @(negedge clk);
      chk("stall_busy", {63'd0, md_stall}, 64'd1);
    end
    @(negedge clk);
    chk("stall_after", {63'd0, md_stall}, 64'd0);
    chk("busy_after", {63'd0, busy}, 64'd0);
    issue(3'd1, 32'd11, 32'd13, 1'b0);
    for (int i = 0; i < MULT_N; i++) begin
      @(negedge clk);
      chk("stall_noD", {63'd0, md_stall}, 64'd0);
    end
    wait_idle();
    md_use_D = 1'b0;

    // 5: reset mid-divide aborts without commit
    issue(3'd3, 32'd1000, 32'd3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    abort_flag = 1'b1;
    exp_q.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    check_regs("abort");
    repeat (DIV_N + 2) @(posedge clk);
    #1;
    check_regs("abort_late");
    issue(3'd1, 32'd2, 32'd3, 1'b0);
    wait_idle();
    chk("t5_lo", {32'd0, lo}, 64'd6);

    // 6: start while busy is ignored; md_out follows mf_sel
    issue(3'd3, 32'hFFFFFF00, 32'd7, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; md_op = 3'd1; A = 32'd7; B = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    check_regs("t6");
    mf_sel = 1'b0; #1;
    chk("mdout_lo", {32'd0, md_out}, {32'd0, m_lo});
    mf_sel = 1'b1; #1;
    chk("mdout_hi", {32'd0, md_out}, {32'd0, m_hi});

    // Signed overflow divide
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle();
    chk("ovf_lo", {32'd0, lo}, 64'h80000000);
    chk("ovf_hi", {32'd0, hi}, 64'h0);

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 16));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      issue(op, a, b, 1'($urandom_range(0, 1)));
      if (op >= 3'd1 && op <= 3'd4) wait_idle();
      md_use_D = 1'b0;
      mf_sel = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_mdout", {32'd0, md_out}, {32'd0, mf_sel ? m_hi : m_lo});
      check_regs("rnd");
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
